// File: rtl/mem_pkg.sv
// Shared types for the memory stage.
// Access sizes, op encoding, FSM states and the decode bundle.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_e;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mem_state_t;

  typedef struct packed {
    logic       op;
    logic [1:0] access_size;
    logic       read_unsigned;
  } mem_params_t;

  // Natural alignment check; size 11 is never legal.
  function automatic logic access_ok(
    input logic [1:0] sz,
    input logic [1:0] off
  );
    logic ok;
    ok = 1'b0;
    case (sz)
      MEM_BYTE: ok = 1'b1;
      MEM_HALF: ok = ~off[0];
      MEM_WORD: ok = (off == 2'b00);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 32-bit data bus.
// Byte enables, store replication, load extract/extend.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        rd_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  logic [31:0] shifted;

  // Steer lanes according to access size and byte offset.
  always_comb begin
    shifted = rdata >> {off, 3'b000};
    be      = 4'b0000;
    wdata   = store_data;
    ldata   = 32'h0;
    case (size)
      MEM_BYTE: begin
        be    = 4'b0001 << off;
        wdata = {4{store_data[7:0]}};
        ldata = rd_unsigned ? {24'h0, shifted[7:0]}
                            : {{24{shifted[7]}}, shifted[7:0]};
      end
      MEM_HALF: begin
        be    = 4'b0011 << off;
        wdata = {2{store_data[15:0]}};
        ldata = rd_unsigned ? {16'h0, shifted[15:0]}
                            : {{16{shifted[15]}}, shifted[15:0]};
      end
      MEM_WORD: begin
        be    = 4'b1111;
        wdata = store_data;
        ldata = shifted;
      end
      default: begin
        be    = 4'b0000;
        wdata = store_data;
        ldata = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: one load/store at a time on a req/ack bus.
// Stalls upstream until the access completes or faults.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned XLEN           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  mem_params_t      mem_params,
  input  logic [XLEN-1:0]  addr,
  input  logic [XLEN-1:0]  store_data,
  output logic             bus_req,
  output logic             bus_we,
  output logic [XLEN-1:0]  bus_addr,
  output logic [3:0]       bus_be,
  output logic [XLEN-1:0]  bus_wdata,
  input  logic             bus_ack,
  input  logic [XLEN-1:0]  bus_rdata,
  output logic             stall,
  output logic             done,
  output logic [XLEN-1:0]  load_data,
  output logic             fault
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);

  mem_state_t  state;
  logic        op_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  logic [1:0]  la_size;
  logic [1:0]  la_off;
  logic        la_uns;
  logic [3:0]  la_be;
  logic [31:0] la_wdata;
  logic [31:0] la_ldata;
  logic        legal;

  // Aligner sees the new request in IDLE, the latched one otherwise.
  always_comb begin
    la_size = size_q;
    la_off  = off_q;
    la_uns  = uns_q;
    if (state == IDLE) begin
      la_size = mem_params.access_size;
      la_off  = addr[1:0];
      la_uns  = mem_params.read_unsigned;
    end
  end

  mem_lane_align u_align (
    .size        (la_size),
    .off         (la_off),
    .rd_unsigned (la_uns),
    .store_data  (store_data),
    .rdata       (bus_rdata),
    .be          (la_be),
    .wdata       (la_wdata),
    .ldata       (la_ldata)
  );

  assign legal   = access_ok(mem_params.access_size, addr[1:0]);
  assign cnt_nxt = cnt + CW'(1);
  assign stall   = (state == BUSY) ||
                   ((state == IDLE) && valid_in);

  // Transaction FSM with registered bus and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= 1'b0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      off_q     <= 2'b00;
      cnt       <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= 4'b0000;
      bus_wdata <= '0;
      done      <= 1'b0;
      fault     <= 1'b0;
      load_data <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            op_q      <= mem_params.op;
            size_q    <= mem_params.access_size;
            uns_q     <= mem_params.read_unsigned;
            off_q     <= addr[1:0];
            bus_addr  <= {addr[XLEN-1:2], 2'b00};
            bus_be    <= la_be;
            bus_we    <= (mem_params.op == MEM_WRITE);
            bus_wdata <= la_wdata;
            load_data <= '0;
            cnt       <= '0;
            if (!legal) begin
              state <= DONE;
              done  <= 1'b1;
              fault <= 1'b1;
            end else begin
              state   <= BUSY;
              bus_req <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= DONE;
            done    <= 1'b1;
            if (op_q == MEM_READ) load_data <= la_ldata;
          end else if ((TIMEOUT_CYCLES != 0) &&
                       (cnt_nxt == CW'(TIMEOUT_CYCLES))) begin
            bus_req <= 1'b0;
            state   <= DONE;
            done    <= 1'b1;
            fault   <= 1'b1;
            cnt     <= cnt_nxt;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        DONE: begin
          state <= IDLE;
          fault <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit.
// Each task drives one scenario and checks against hand values.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  mem_params_t mem_params;
  logic [31:0] addr, store_data;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic        stall, done, fault;
  logic [31:0] load_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(4), .XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .mem_params (mem_params),
    .addr       (addr),
    .store_data (store_data),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .stall      (stall),
    .done       (done),
    .load_data  (load_data),
    .fault      (fault)
  );

  // Runs one access starting at posedge+1 in IDLE; ack_at=0 means never ack.
  task automatic txn(
    input  logic        op,
    input  logic [1:0]  sz,
    input  logic        uns,
    input  logic [31:0] a,
    input  logic [31:0] sd,
    input  logic [31:0] rd,
    input  int          ack_at,
    output int          stl,
    output int          req,
    output int          dlat,
    output logic        flt,
    output logic [31:0] ld,
    output logic [3:0]  be,
    output logic [31:0] wd,
    output logic [31:0] ba,
    output logic        we,
    output logic        dn2
  );
    stl = 0; req = 0; dlat = -1;
    flt = 1'bx; ld = 'x; be = 'x; wd = 'x; ba = 'x; we = 1'bx;
    dn2 = 1'bx;
    mem_params = '{op: op, access_size: sz, read_unsigned: uns};
    addr = a; store_data = sd; bus_rdata = rd;
    bus_ack = 1'b0; valid_in = 1'b1;
    #1;
    if (stall) stl++;
    @(posedge clk); #1;
    valid_in = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      bus_ack = (c == ack_at);
      #1;
      if (stall) stl++;
      if (bus_req) req++;
      if (c == 1) begin
        be = bus_be; wd = bus_wdata; ba = bus_addr; we = bus_we;
      end
      if (done) begin
        dlat = c; flt = fault; ld = load_data;
        bus_ack = 1'b0;
        @(posedge clk); #1;
        dn2 = done;
        break;
      end
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({bus_req, done, fault, stall, bus_we} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctl got %b want 00000",
               {bus_req, done, fault, stall, bus_we});
    end
    n_cmp++;
    if ({load_data, bus_addr, bus_wdata, bus_be} !== 100'h0) begin
      n_err++;
      $display("FAIL reset_data got %h/%h/%h/%h want 0",
               load_data, bus_addr, bus_wdata, bus_be);
    end
  endtask

  task automatic test_word_store;
    int s, r, d; logic f, w, n; logic [31:0] l, wd, ba; logic [3:0] be;
    txn(MEM_WRITE, MEM_WORD, 1'b0, 32'h1000_0008, 32'hDEAD_BEEF,
        32'h0, 2, s, r, d, f, l, be, wd, ba, w, n);
    n_cmp++;
    if ({w, be} !== 5'b1_1111) begin
      n_err++; $display("FAIL ws_we_be got %b%b want 11111", w, be);
    end
    n_cmp++;
    if (wd !== 32'hDEAD_BEEF || ba !== 32'h1000_0008) begin
      n_err++; $display("FAIL ws_data_addr got %h %h want deadbeef 10000008", wd, ba);
    end
    n_cmp++;
    if (s !== 3 || r !== 2 || d !== 3) begin
      n_err++; $display("FAIL ws_timing got stall=%0d req=%0d done@%0d want 3 2 3", s, r, d);
    end
    n_cmp++;
    if (f !== 1'b0 || l !== 32'h0 || n !== 1'b0) begin
      n_err++; $display("FAIL ws_result got f=%b ld=%h done2=%b want 0 0 0", f, l, n);
    end
  endtask

  task automatic test_byte_load;
    int s, r, d; logic f, w, n; logic [31:0] l, wd, ba; logic [3:0] be;
    txn(MEM_READ, MEM_BYTE, 1'b0, 32'h2000_0103, 32'h0,
        32'h80FF_0000, 1, s, r, d, f, l, be, wd, ba, w, n);
    n_cmp++;
    if (be !== 4'b1000 || w !== 1'b0 || ba !== 32'h2000_0100) begin
      n_err++; $display("FAIL lb_bus got be=%b we=%b a=%h want 1000 0 20000100", be, w, ba);
    end
    n_cmp++;
    if (l !== 32'hFFFF_FF80 || f !== 1'b0) begin
      n_err++; $display("FAIL lb_signed got %h f=%b want ffffff80 0", l, f);
    end
    n_cmp++;
    if (s !== 2 || d !== 2 || r !== 1) begin
      n_err++; $display("FAIL lb_minlat got stall=%0d done@%0d req=%0d want 2 2 1", s, d, r);
    end
    txn(MEM_READ, MEM_BYTE, 1'b1, 32'h2000_0103, 32'h0,
        32'h80FF_0000, 1, s, r, d, f, l, be, wd, ba, w, n);
    n_cmp++;
    if (l !== 32'h0000_0080) begin
      n_err++; $display("FAIL lbu got %h want 00000080", l);
    end
  endtask

  task automatic test_half;
    int s, r, d; logic f, w, n; logic [31:0] l, wd, ba; logic [3:0] be;
    txn(MEM_WRITE, MEM_HALF, 1'b0, 32'h3000_0012, 32'h1234_ABCD,
        32'h0, 1, s, r, d, f, l, be, wd, ba, w, n);
    n_cmp++;
    if (be !== 4'b1100 || wd !== 32'hABCD_ABCD) begin
      n_err++; $display("FAIL sh_lanes got be=%b wd=%h want 1100 abcdabcd", be, wd);
    end
    txn(MEM_READ, MEM_HALF, 1'b0, 32'h3000_0012, 32'h0,
        32'h7FFF_0000, 2, s, r, d, f, l, be, wd, ba, w, n);
    n_cmp++;
    if (l !== 32'h0000_7FFF || f !== 1'b0 || be !== 4'b1100) begin
      n_err++; $display("FAIL lh got %h f=%b be=%b want 00007fff 0 1100", l, f, be);
    end
    txn(MEM_READ, MEM_HALF, 1'b0, 32'h3000_0010, 32'h0,
        32'h0000_8001, 1, s, r, d, f, l, be, wd, ba, w, n);
    n_cmp++;
    if (l !== 32'hFFFF_8001 || be !== 4'b0011) begin
      n_err++; $display("FAIL lh_neg got %h be=%b want ffff8001 0011", l, be);
    end
  endtask

  task automatic test_misaligned;
    int s, r, d; logic f, w, n; logic [31:0] l, wd, ba; logic [3:0] be;
    txn(MEM_READ, MEM_WORD, 1'b0, 32'h4000_0002, 32'h0,
        32'hFFFF_FFFF, 1, s, r, d, f, l, be, wd, ba, w, n);
    n_cmp++;
    if (r !== 0 || d !== 1 || f !== 1'b1 || l !== 32'h0 || s !== 1) begin
      n_err++;
      $display("FAIL mis_word got req=%0d done@%0d f=%b ld=%h stall=%0d want 0 1 1 0 1",
               r, d, f, l, s);
    end
    txn(MEM_READ, 2'b11, 1'b0, 32'h4000_0000, 32'h0,
        32'hFFFF_FFFF, 1, s, r, d, f, l, be, wd, ba, w, n);
    n_cmp++;
    if (r !== 0 || d !== 1 || f !== 1'b1 || l !== 32'h0) begin
      n_err++;
      $display("FAIL bad_size got req=%0d done@%0d f=%b ld=%h want 0 1 1 0", r, d, f, l);
    end
    txn(MEM_WRITE, MEM_HALF, 1'b0, 32'h4000_0001, 32'h5555,
        32'h0, 1, s, r, d, f, l, be, wd, ba, w, n);
    n_cmp++;
    if (r !== 0 || f !== 1'b1) begin
      n_err++; $display("FAIL mis_half got req=%0d f=%b want 0 1", r, f);
    end
  endtask

  task automatic test_timeout;
    int s, r, d; logic f, w, n; logic [31:0] l, wd, ba; logic [3:0] be;
    txn(MEM_READ, MEM_WORD, 1'b0, 32'h5000_0000, 32'h0,
        32'h1122_3344, 0, s, r, d, f, l, be, wd, ba, w, n);
    n_cmp++;
    if (r !== 4 || d !== 5 || f !== 1'b1 || l !== 32'h0) begin
      n_err++;
      $display("FAIL timeout got req=%0d done@%0d f=%b ld=%h want 4 5 1 0", r, d, f, l);
    end
    txn(MEM_READ, MEM_WORD, 1'b0, 32'h5000_0000, 32'h0,
        32'h1122_3344, 4, s, r, d, f, l, be, wd, ba, w, n);
    n_cmp++;
    if (r !== 4 || d !== 5 || f !== 1'b0 || l !== 32'h1122_3344) begin
      n_err++;
      $display("FAIL ack_wins got req=%0d done@%0d f=%b ld=%h want 4 5 0 11223344", r, d, f, l);
    end
  endtask

  task automatic test_reset_busy;
    int s, r, d; logic f, w, n; logic [31:0] l, wd, ba; logic [3:0] be;
    mem_params = '{op: MEM_READ, access_size: MEM_WORD, read_unsigned: 1'b0};
    addr = 32'h6000_0000; bus_ack = 1'b0; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    #1;
    n_cmp++;
    if (bus_req !== 1'b1 || stall !== 1'b1) begin
      n_err++; $display("FAIL rb_busy got req=%b stall=%b want 1 1", bus_req, stall);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus_req, stall, done} !== 3'b000) begin
      n_err++; $display("FAIL rb_async got %b want 000", {bus_req, stall, done});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    txn(MEM_READ, MEM_WORD, 1'b0, 32'h6000_0004, 32'h0,
        32'hCAFE_F00D, 1, s, r, d, f, l, be, wd, ba, w, n);
    n_cmp++;
    if (d !== 2 || f !== 1'b0 || l !== 32'hCAFE_F00D) begin
      n_err++; $display("FAIL rb_after got done@%0d f=%b ld=%h want 2 0 cafef00d", d, f, l);
    end
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; bus_ack = 1'b0;
    mem_params = '0; addr = '0; store_data = '0; bus_rdata = '0;
    #12;
    test_reset;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    test_word_store;
    test_byte_load;
    test_half;
    test_misaligned;
    test_timeout;
    test_reset_busy;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
